// File: rtl/sub_serial_reg.sv
// Bit-serial registered subtractor: computes iData0 - iData1 one bit per enabled
// cycle, LSB first, and presents a BITWIDTH+1-bit two's-complement difference.
module sub_serial_reg #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    input  logic [BITWIDTH-1:0] iData0,
    input  logic [BITWIDTH-1:0] iData1,
    output logic [BITWIDTH:0]   oData,
    output logic                oBusy,
    output logic                oDone
);

    localparam int CNT_W = $clog2(BITWIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [BITWIDTH-1:0]  r_a;
    logic [BITWIDTH-1:0]  r_b;
    logic [BITWIDTH-2:0]  r_d;
    logic                 r_borrow;
    logic [CNT_W-1:0]     r_cnt;
    logic [BITWIDTH:0]    r_data;

    state_t               w_state_nxt;
    logic [BITWIDTH-1:0]  w_a_nxt;
    logic [BITWIDTH-1:0]  w_b_nxt;
    logic [BITWIDTH-2:0]  w_d_nxt;
    logic                 w_borrow_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BITWIDTH:0]    w_data_nxt;

    logic                 w_bit;
    logic                 w_borrow_bit;
    logic [BITWIDTH-1:0]  w_d_full;

    // Full-subtractor cell for the current bit position.
    assign w_bit        = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_bit = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

    // D holds only the W-1 bits produced so far; the final bit is joined
    // directly into the result on the completion edge.
    assign w_d_full = {w_bit, r_d};

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_d_nxt      = r_d;
        w_borrow_nxt = r_borrow;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    w_a_nxt      = iData0;
                    w_b_nxt      = iData1;
                    w_borrow_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_RUN;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end

            ST_RUN: begin
                w_a_nxt      = {1'b0, r_a[BITWIDTH-1:1]};
                w_b_nxt      = {1'b0, r_b[BITWIDTH-1:1]};
                w_d_nxt      = w_d_full[BITWIDTH-1:1];
                w_borrow_nxt = w_borrow_bit;
                w_cnt_nxt    = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_BIT) begin
                    w_data_nxt  = {w_borrow_bit, w_d_full};
                    w_state_nxt = ST_DONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_data   <= '0;
        end else if (iClr) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_data   <= '0;
        end else if (iEn) begin
            r_state  <= w_state_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_d      <= w_d_nxt;
            r_borrow <= w_borrow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
        end
    end

    // Status flags decode the state flops directly; no input reaches an output.
    assign oData = r_data;
    assign oBusy = (r_state == ST_RUN);
    assign oDone = (r_state == ST_DONE);

endmodule

// File: tb/tb_sub_serial_reg.sv
// Self-checking bench for sub_serial_reg: directed vector table, multi-cycle
// corner sequences, and randomized operations against an arithmetic model.
module tb_sub_serial_reg;

    localparam int W = 8;

    logic           iClk;
    logic           iRstN;
    logic           iEn;
    logic           iClr;
    logic           iStart;
    logic [W-1:0]   iData0;
    logic [W-1:0]   iData1;
    logic [W:0]     oData;
    logic           oBusy;
    logic           oDone;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W:0] exp_data;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    vec_t vecs[5];

    sub_serial_reg #(.BITWIDTH(W)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iStart (iStart),
        .iData0 (iData0),
        .iData1 (iData1),
        .oData  (oData),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Difference as plain W+1-bit two's-complement arithmetic.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_tick();
        tick();
        check("idle_done", 32'(oDone), 0);
        check("idle_busy", 32'(oBusy), 0);
        check("idle_data", 32'(oData), 32'(exp_data));
    endtask

    // Starts an operation (state must be IDLE or DONE) and runs until oDone.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stalls, input bit hold_start, input logic [W:0] exp);
        int  cyc;
        int  en_cnt;
        int  stall_left;
        bit  got;
        bit  en_now;
        iData0 = a;
        iData1 = b;
        iStart = 1'b1;
        iEn    = 1'b1;
        tick();
        check("start_busy", 32'(oBusy), 1);
        check("start_done", 32'(oDone), 0);
        if (hold_start) begin
            iData0 = ~a;
            iData1 = ~b;
        end else begin
            iStart = 1'b0;
        end
        cyc = 0;
        en_cnt = 0;
        stall_left = stalls;
        got = 1'b0;
        while (!got && cyc < 100) begin
            en_now = 1'b1;
            if (stall_left > 0 && en_cnt >= 1 && en_cnt <= 6 &&
                ($urandom_range(0, 1) == 1 || en_cnt == 6)) begin
                en_now = 1'b0;
                stall_left--;
            end
            iEn = en_now;
            tick();
            cyc++;
            if (en_now) en_cnt++;
            if (oDone === 1'b1) begin
                got = 1'b1;
            end else begin
                check("run_busy", 32'(oBusy), 1);
                check("run_hold", 32'(oData), 32'(exp_data));
            end
        end
        iStart = 1'b0;
        iEn    = 1'b1;
        check("done_seen", 32'(got), 1);
        check("latency", 32'(cyc), 32'(W + stalls));
        check("done_busy", 32'(oBusy), 0);
        check("result", 32'(oData), 32'(exp));
        check("borrow_msb", 32'(oData[W]), 32'(a < b));
        exp_data = exp;
    endtask

    task automatic done_stall(input int n);
        iEn = 1'b0;
        repeat (n) begin
            tick();
            check("stall_done_hi", 32'(oDone), 1);
            check("stall_done_busy", 32'(oBusy), 0);
            check("stall_done_data", 32'(oData), 32'(exp_data));
        end
        iEn = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'd200, b: 8'd55,  exp: 9'h091};
        vecs[1] = '{a: 8'd55,  b: 8'd200, exp: 9'h16F};
        vecs[2] = '{a: 8'd0,   b: 8'd255, exp: 9'h101};
        vecs[3] = '{a: 8'd255, b: 8'd0,   exp: 9'h0FF};
        vecs[4] = '{a: 8'd77,  b: 8'd77,  exp: 9'h000};

        iRstN  = 1'b0;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iStart = 1'b0;
        iData0 = '0;
        iData1 = '0;
        exp_data = '0;

        #23;
        check("rst_data", 32'(oData), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        iRstN = 1'b1;
        repeat (20) idle_tick();

        // Directed vectors, each followed by one idle cycle to see oDone drop.
        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, 1'b0, vecs[i].exp);
            idle_tick();
        end

        // Stall mid-RUN, then stall during DONE.
        do_op(8'd100, 8'd1, 3, 1'b0, 9'h063);
        done_stall(2);
        idle_tick();

        // Back-to-back start issued in the DONE cycle.
        do_op(8'd200, 8'd55, 0, 1'b0, 9'h091);
        do_op(8'd10, 8'd20, 0, 1'b0, 9'h1F6);
        idle_tick();

        // Start held high throughout RUN with different data on the bus.
        do_op(8'd9, 8'd3, 0, 1'b1, 9'h006);
        idle_tick();
        do_op(8'd200, 8'd55, 0, 1'b0, 9'h091);
        idle_tick();

        // Synchronous clear partway through an operation.
        iData0 = 8'd9;
        iData1 = 8'd3;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (4) tick();
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        exp_data = '0;
        check("clr_data", 32'(oData), 0);
        check("clr_busy", 32'(oBusy), 0);
        check("clr_done", 32'(oDone), 0);
        repeat (10) idle_tick();
        do_op(8'd9, 8'd3, 0, 1'b0, 9'h006);
        idle_tick();

        // Asynchronous reset between edges during RUN.
        iData0 = 8'd100;
        iData1 = 8'd1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        repeat (3) tick();
        #2 iRstN = 1'b0;
        #1;
        exp_data = '0;
        check("arst_data", 32'(oData), 0);
        check("arst_busy", 32'(oBusy), 0);
        check("arst_done", 32'(oDone), 0);
        #2 iRstN = 1'b1;
        repeat (3) idle_tick();
        do_op(8'd200, 8'd55, 0, 1'b0, 9'h091);
        idle_tick();

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 0) begin
                ra = '0;
                rb = '0;
            end else if (i == 1) begin
                ra = '1;
                rb = '1;
            end
            do_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ref_sub(ra, rb));
            if ($urandom_range(0, 3) == 0) done_stall(1);
            if ($urandom_range(0, 2) != 0) idle_tick();
        end
        idle_tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sub_serial_reg.md
# sub_serial_reg

Bit-serial registered subtractor: the inverse-direction counterpart of the registered adder in the arithmetic module library. It computes `iData0 - iData1` one bit per enabled cycle, LSB first, with a start/busy/done handshake. It uses the same enable/clear/width conventions as the parallel arithmetic registers, so it can drop in wherever area matters more than latency. The result is a `BITWIDTH+1`-bit two's-complement value whose MSB is the final borrow.

## Interface
- `BITWIDTH`, default 8: operand width, taken from the block's `.def` file; must be ≥ 2.

- `iClk` in 1: clock; all state changes on its rising edge.
- `iRstN` in 1: asynchronous, active-low reset.
- `iEn` in 1: advance enable; when low, all state holds (stall).
- `iClr` in 1: synchronous clear; highest priority after reset.
- `iStart` in 1: start request, sampled only when the block can accept it (see Operation).
- `iData0` in `BITWIDTH`: minuend, captured on the accepted start.
- `iData1` in `BITWIDTH`: subtrahend, captured on the accepted start.
- `oData` out `BITWIDTH+1`: difference, two's complement; updated only on completion; holds otherwise.
- `oBusy` out 1: high while a subtraction is in progress (state RUN).
- `oDone` out 1: single-cycle completion strobe (state DONE).

## Operation
- **Internal state:**
  - operand shift registers A and B, `BITWIDTH` bits each;
  - result shift register D, `BITWIDTH` bits;
  - borrow flop;
  - bit counter, `$clog2(BITWIDTH)` bits;
  - FSM with states IDLE, RUN, DONE.
- **Priority per edge:** `~iRstN` > `iClr` > `~iEn` (hold everything, including `oDone`) > normal operation.
- **IDLE:**
  - If `iStart`=1: load A←`iData0`, B←`iData1`, borrow←0, counter←0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, one bit per edge, with a=A[0], b=B[0], c=borrow:
  - d = a^b^c;
  - borrow ← (~a&b) | (~(a^b)&c);
  - D ← {d, D[BITWIDTH-1:1]};
  - A, B shift right by one;
  - counter += 1.
- **RUN completion:** on the edge where counter = `BITWIDTH-1`:
  - `oData` ← {borrow_next, d, D[BITWIDTH-1:1]};
  - state → DONE.
- **DONE:** lasts one enabled cycle.
  - If `iStart`=1: accept a new operation exactly as in IDLE and go to RUN (back-to-back throughput).
  - Otherwise go to IDLE.
- **`iStart` in RUN:** ignored; no queuing.
- **Arithmetic:**
  - The result range is −(2^W−1)…2^W−1, which fits exactly in W+1-bit two's complement.
  - `oData[BITWIDTH]` = 1 iff `iData0` < `iData1`.
  - No overflow is possible.
- **`iClr`=1 at any state:** state→IDLE, `oData`←0, `oBusy`/`oDone` low, A/B/D/borrow/counter←0; any in-flight result is discarded.
- **Reset mid-operation:** identical to clear, taking effect asynchronously.

## Timing
- Reset values: `oData`=0, `oBusy`=0, `oDone`=0, state IDLE.
- Start accepted at edge E0:
  - `oBusy` is high from after E0 through edge E`BITWIDTH`.
  - Bit processing occurs on edges E1…E`BITWIDTH`.
  - `oData` updates at E`BITWIDTH`.
  - `oDone` is high for exactly one cycle after E`BITWIDTH`, coincident with the new `oData`.
- Latency: `BITWIDTH` enabled edges from start acceptance to `oDone`. Each `iEn`=0 cycle adds exactly one cycle of latency.
- Stalls during DONE hold `oDone` high until the next enabled edge.
- Throughput: one result per `BITWIDTH`+1 cycles, using a start issued in the DONE cycle.
- `oBusy` and `oDone` are never high simultaneously.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset/idle:** with `iRstN` low, then released and no start → `oData`=0x000, `oBusy`=0, `oDone`=0 for 20 cycles.
- **Basic subtraction (W=8):**
  - 200−55 → `oData`=0x091;
  - 55−200 → 0x16F;
  - 0−255 → 0x101;
  - 255−0 → 0x0FF;
  - 77−77 → 0x000;
  - each result arrives with `oDone` exactly 8 cycles after the start edge, lasting 1 cycle.
- **Stall:** 100−1 with `iEn` low for 3 random cycles mid-RUN → `oData`=0x063, `oDone` at 11 cycles after start; a stall during DONE extends `oDone`.
- **Back-to-back and ignored start:**
  - `iStart` pulsed in DONE with 10−20 → next `oData`=0x1F6 after 8 more cycles.
  - `iStart` asserted throughout RUN → no change to the operands in flight.
- **Clear mid-operation:** `iClr` at bit 4 of 9−3 → next cycle `oData`=0, `oBusy`=0, no `oDone`; a new start of 9−3 → 0x006.
- **Async reset mid-operation:** `iRstN` low between clock edges during RUN → outputs zero immediately; after release, a new operation completes correctly.
